// File: rtl/button_conditioner_pkg.sv
// Shared types, default timing constants and sizing helper for the pushbutton conditioner.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT_DELAY,
        WAIT_REPEAT
    } strobe_state_e;

    // Defaults assume a 25 MHz pixel clock.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
    localparam int unsigned DEF_PULSE_CYCLES    = 8;
    localparam int unsigned DEF_REPEAT_DELAY    = 12500000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 2500000;

    // Bits needed to hold any value in 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One pushbutton lane: 2-flop synchroniser, debouncer and press/auto-repeat strobe FSM.
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   IDLE        | strobe high, waiting for an uncancelled debounced press
//   PULSE       | strobe low for PULSE_CYCLES; always runs to completion
//   WAIT_DELAY  | strobe high, held after first pulse, waiting for first repeat
//   WAIT_REPEAT | strobe high, held after a repeat pulse, waiting for the next
//
// The shared timer is a down-counter loaded at every pulse start with
// (interval - 1); it hits zero on the cycle before the next pulse is due.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    input  logic cancel_i,
    output logic deb_no,
    output logic strobe_no
);

    localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned TW = cnt_width(REPEAT_DELAY);

    localparam logic [DW-1:0] DEB_MAX     = DW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);
    // Timer values seen on the last low cycle of a first / repeat pulse.
    localparam logic [TW-1:0] FIRST_END   = TW'(REPEAT_DELAY - PULSE_CYCLES);
    localparam logic [TW-1:0] REPEAT_END  = TW'(REPEAT_PERIOD - PULSE_CYCLES);

    logic [1:0]    sync_q;
    logic          deb_q, deb_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    strobe_state_e state_q;
    logic [TW-1:0] tmr_q;
    logic          first_q;
    logic          strobe_q;

    // Bring the asynchronous key into the clock domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], key_ni};
    end

    // Count disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync_q[1] != deb_q) begin
            if (deb_cnt_q == DEB_MAX) deb_d     = sync_q[1];
            else                      deb_cnt_d = deb_cnt_q + DW'(1);
        end
    end

    // Debounced level and its stability counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deb_q     <= 1'b1;
            deb_cnt_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Strobe FSM with registered active-low output; cancel overrides everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            first_q  <= 1'b0;
            strobe_q <= 1'b1;
        end else if (cancel_i) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            first_q  <= 1'b0;
            strobe_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!deb_q) begin
                        state_q  <= PULSE;
                        tmr_q    <= DELAY_LOAD;
                        first_q  <= 1'b1;
                        strobe_q <= 1'b0;
                    end
                end
                PULSE: begin
                    tmr_q <= tmr_q - TW'(1);
                    if (tmr_q == (first_q ? FIRST_END : REPEAT_END)) begin
                        strobe_q <= 1'b1;
                        if (deb_q) begin
                            state_q <= IDLE;
                            tmr_q   <= '0;
                        end else if (first_q) begin
                            state_q <= WAIT_DELAY;
                        end else begin
                            state_q <= WAIT_REPEAT;
                        end
                    end
                end
                WAIT_DELAY, WAIT_REPEAT: begin
                    if (deb_q) begin
                        state_q <= IDLE;
                        tmr_q   <= '0;
                    end else if (tmr_q == '0) begin
                        state_q  <= PULSE;
                        tmr_q    <= PERIOD_LOAD;
                        first_q  <= 1'b0;
                        strobe_q <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    strobe_q <= 1'b1;
                end
            endcase
        end
    end

    assign deb_no    = deb_q;
    assign strobe_no = strobe_q;

endmodule

// File: rtl/button_conditioner.sv
// Four-button conditioner: per-key lanes plus opposite-pair cancellation.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic iVGA_CLK,
    input  logic iRST_n,
    input  logic iKEY_up,
    input  logic iKEY_down,
    input  logic iKEY_left,
    input  logic iKEY_right,
    output logic up,
    output logic down,
    output logic left,
    output logic right
);

    logic deb_up_n, deb_down_n, deb_left_n, deb_right_n;
    logic cancel_ud, cancel_lr;

    // Both keys of an opposite pair held means no intent; silence both lanes.
    assign cancel_ud = ~deb_up_n   & ~deb_down_n;
    assign cancel_lr = ~deb_left_n & ~deb_right_n;

    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .PULSE_CYCLES(PULSE_CYCLES),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_up (
        .clk_i(iVGA_CLK), .rst_ni(iRST_n), .key_ni(iKEY_up),
        .cancel_i(cancel_ud), .deb_no(deb_up_n), .strobe_no(up)
    );

    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .PULSE_CYCLES(PULSE_CYCLES),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_down (
        .clk_i(iVGA_CLK), .rst_ni(iRST_n), .key_ni(iKEY_down),
        .cancel_i(cancel_ud), .deb_no(deb_down_n), .strobe_no(down)
    );

    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .PULSE_CYCLES(PULSE_CYCLES),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_left (
        .clk_i(iVGA_CLK), .rst_ni(iRST_n), .key_ni(iKEY_left),
        .cancel_i(cancel_lr), .deb_no(deb_left_n), .strobe_no(left)
    );

    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .PULSE_CYCLES(PULSE_CYCLES),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_right (
        .clk_i(iVGA_CLK), .rst_ni(iRST_n), .key_ni(iKEY_right),
        .cancel_i(cancel_lr), .deb_no(deb_right_n), .strobe_no(right)
    );

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with fixed expected timing,
// plus a cycle-accurate reference model driven by random key activity.
module tb_button_conditioner;

    localparam int DEB = 4;
    localparam int PUL = 8;
    localparam int DLY = 40;
    localparam int PER = 20;
    localparam int HN  = 4096;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_n = 4'hF;   // [0]=up [1]=down [2]=left [3]=right
    logic       up, down, left, right;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PUL),
        .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n),
        .iKEY_up(key_n[0]), .iKEY_down(key_n[1]),
        .iKEY_left(key_n[2]), .iKEY_right(key_n[3]),
        .up(up), .down(down), .left(left), .right(right)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: raw key history, debounced level, strobe schedule.
    int         cyc;
    logic       hist [4][HN];
    logic       m_deb [4];
    bit         m_hold [4];
    int         m_ls [4];      // edge index of most recent pulse start
    int         m_ns [4];      // edge index at which next repeat is due
    logic [3:0] exp_o;

    function automatic logic raw_at(int ch, int idx);
        return (idx <= 0) ? 1'b1 : hist[ch][idx % HN];
    endfunction

    task automatic model_reset();
        cyc = 0;
        exp_o = 4'hF;
        for (int ch = 0; ch < 4; ch++) begin
            m_deb[ch]  = 1'b1;
            m_hold[ch] = 1'b0;
            m_ls[ch]   = -1000;
            m_ns[ch]   = -1000;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        key_n = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Advance one clock edge, update the model, and return #1 after the edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        for (int ch = 0; ch < 4; ch++) hist[ch][cyc % HN] = key_n[ch];
        for (int ch = 0; ch < 4; ch++) begin
            bit pressed;
            bit canc;
            pressed = !m_deb[ch];
            canc    = !m_deb[ch] && !m_deb[ch ^ 1];
            if (canc) begin
                m_hold[ch] = 1'b0;
                m_ls[ch]   = -1000;
            end else if (cyc < m_ls[ch] + PUL) begin
                // pulse still running; it is never cut short by release
            end else if (!m_hold[ch]) begin
                if (pressed) begin
                    m_hold[ch] = 1'b1;
                    m_ls[ch]   = cyc;
                    m_ns[ch]   = cyc + DLY;
                end
            end else if (!pressed) begin
                m_hold[ch] = 1'b0;
            end else if (cyc == m_ns[ch]) begin
                m_ls[ch] = cyc;
                m_ns[ch] = cyc + PER;
            end
        end
        // Debounced level flips once DEB+1 consecutive synchronised samples
        // (raw delayed by two edges) all disagree with it.
        for (int ch = 0; ch < 4; ch++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int u = cyc - DEB; u <= cyc; u++)
                if (raw_at(ch, u - 2) == m_deb[ch]) all_diff = 1'b0;
            if (all_diff) m_deb[ch] = !m_deb[ch];
            exp_o[ch] = !(cyc >= m_ls[ch] && cyc < m_ls[ch] + PUL);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_n = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({right, left, down, up} !== 4'hF) begin
            n_bad++;
            $display("FAIL reset_hold got=%b exp=1111", {right, left, down, up});
        end
        apply_reset();
        key_n = 4'hE;
        for (int t = 1; t <= 14; t++) tick();
        n_cmp++;
        if (up !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_prepulse got=%b exp=0", up);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (up !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_async got=%b exp=1", up);
        end
        key_n = 4'hF;
    endtask

    task automatic test_clean_press();
        apply_reset();
        for (int t = 1; t <= 45; t++) begin
            key_n[0] = (t >= 10 && t <= 39) ? 1'b0 : 1'b1;
            tick();
            n_cmp++;
            if (up !== ((t >= 17 && t <= 24) ? 1'b0 : 1'b1)) begin
                n_bad++;
                $display("FAIL clean_press t=%0d got=%b", t, up);
            end
            n_cmp++;
            if ({right, left, down, up} !== exp_o) begin
                n_bad++;
                $display("FAIL clean_model t=%0d got=%b exp=%b", t, {right, left, down, up}, exp_o);
            end
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int t = 1; t <= 50; t++) begin
            key_n[2] = (t <= 40 && ((t - 1) % 5) < 3) ? 1'b0 : 1'b1;
            tick();
            n_cmp++;
            if (left !== 1'b1) begin
                n_bad++;
                $display("FAIL bounce t=%0d got=%b exp=1", t, left);
            end
            n_cmp++;
            if ({right, left, down, up} !== exp_o) begin
                n_bad++;
                $display("FAIL bounce_model t=%0d got=%b exp=%b", t, {right, left, down, up}, exp_o);
            end
        end
    endtask

    task automatic test_auto_repeat();
        int starts [5] = '{12, 52, 72, 92, 112};
        apply_reset();
        for (int t = 1; t <= 150; t++) begin
            logic want;
            key_n[3] = (t >= 5 && t <= 124) ? 1'b0 : 1'b1;
            tick();
            want = 1'b1;
            foreach (starts[i]) if (t >= starts[i] && t < starts[i] + 8) want = 1'b0;
            n_cmp++;
            if (right !== want) begin
                n_bad++;
                $display("FAIL repeat t=%0d got=%b exp=%b", t, right, want);
            end
            n_cmp++;
            if ({right, left, down, up} !== exp_o) begin
                n_bad++;
                $display("FAIL repeat_model t=%0d got=%b exp=%b", t, {right, left, down, up}, exp_o);
            end
        end
    endtask

    task automatic test_early_release();
        apply_reset();
        for (int t = 1; t <= 70; t++) begin
            key_n[1] = (t >= 5 && t <= 13) ? 1'b0 : 1'b1;
            tick();
            n_cmp++;
            if (down !== ((t >= 12 && t <= 19) ? 1'b0 : 1'b1)) begin
                n_bad++;
                $display("FAIL early_release t=%0d got=%b", t, down);
            end
            n_cmp++;
            if ({right, left, down, up} !== exp_o) begin
                n_bad++;
                $display("FAIL early_model t=%0d got=%b exp=%b", t, {right, left, down, up}, exp_o);
            end
        end
    endtask

    task automatic test_cancel();
        apply_reset();
        for (int t = 1; t <= 85; t++) begin
            logic want_up;
            key_n[0] = (t >= 5 && t <= 69) ? 1'b0 : 1'b1;
            key_n[1] = (t >= 10 && t <= 40) ? 1'b0 : 1'b1;
            tick();
            want_up = ((t >= 12 && t <= 16) || (t >= 48 && t <= 55)) ? 1'b0 : 1'b1;
            n_cmp++;
            if ({down, up} !== {1'b1, want_up}) begin
                n_bad++;
                $display("FAIL cancel t=%0d got down/up=%b exp=%b", t, {down, up}, {1'b1, want_up});
            end
            n_cmp++;
            if ({right, left, down, up} !== exp_o) begin
                n_bad++;
                $display("FAIL cancel_model t=%0d got=%b exp=%b", t, {right, left, down, up}, exp_o);
            end
        end
    endtask

    task automatic test_random();
        int run [4];
        apply_reset();
        for (int ch = 0; ch < 4; ch++) run[ch] = $urandom_range(1, 30);
        for (int t = 1; t <= 1500; t++) begin
            for (int ch = 0; ch < 4; ch++) begin
                run[ch]--;
                if (run[ch] <= 0) begin
                    key_n[ch] = ~key_n[ch];
                    run[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                          : $urandom_range(5, 90);
                end
            end
            tick();
            n_cmp++;
            if ({right, left, down, up} !== exp_o) begin
                n_bad++;
                $display("FAIL random t=%0d got=%b exp=%b", t, {right, left, down, up}, exp_o);
            end
        end
        key_n = 4'hF;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_early_release();
        test_cancel();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
